// File: rtl/inst_rom_loader_if.sv
// ---------------------------------------------------------------------------
// inst_rom_loader_if
//
// Bundles the two buses of the instruction ROM:
//   fetch port : rom_en, rom_addr (from the core PC), rom_inst (back to IF_ID)
//   load port  : load_start/load_valid/load_byte/load_last from the boot
//                source, load_ready/load_busy/load_done/load_err/load_words
//                status back to it.
// master = core + boot source side, slave = the ROM/loader itself.
// ---------------------------------------------------------------------------
interface inst_rom_loader_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  rom_en;
    logic [31:0]           rom_addr;
    logic [31:0]           rom_inst;

    logic                  load_start;
    logic                  load_valid;
    logic [7:0]            load_byte;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_busy;
    logic                  load_done;
    logic                  load_err;
    logic [DEPTH_LOG2:0]   load_words;

    modport master (
        output rom_en, rom_addr, load_start, load_valid, load_byte, load_last,
        input  rom_inst, load_ready, load_busy, load_done, load_err, load_words
    );

    modport slave (
        input  rom_en, rom_addr, load_start, load_valid, load_byte, load_last,
        output rom_inst, load_ready, load_busy, load_done, load_err, load_words
    );
endinterface

// File: rtl/inst_rom_loader.sv
// ---------------------------------------------------------------------------
// inst_rom_loader
//
// Instruction memory for the core's fetch port plus a byte-serial boot loader.
//   clk   : system clock, all state changes on the rising edge
//   rst   : synchronous active-high reset (does not clear the word array)
//   bus   : inst_rom_loader_if.slave
//     rom_en/rom_addr -> rom_inst  combinational fetch, NOP (0) while loading,
//                                  when disabled, or when the address is
//                                  beyond the array
//     load_*                       valid/ready byte stream, big-endian words,
//                                  load_last closes the image (partial words
//                                  are zero-padded)
// ---------------------------------------------------------------------------
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input logic              clk,
    input logic              rst,
    inst_rom_loader_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LAST_WORD = {1'b0, {DEPTH_LOG2{1'b1}}};
    localparam logic [DEPTH_LOG2:0] ONE_WORD  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state_reg, state_next;
    // Word counter doubles as the write pointer: both clear together on
    // entering LOAD and advance together on every word write.
    logic [DEPTH_LOG2:0] words_reg, words_next;
    logic [1:0]          cnt_reg, cnt_next;
    logic [31:0]         asm_reg, asm_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;

    logic [31:0]         word_fill;
    logic                ready_int;
    logic                accept;
    logic                wr_en;

    logic [31:0]         mem [DEPTH];

    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic                  fetch_hit;
    logic                  unused_addr_bits;

    // ---------------- fetch port ----------------
    assign fetch_idx        = bus.rom_addr[DEPTH_LOG2+1:2];
    assign fetch_hit        = bus.rom_en && (state_reg != LOAD) &&
                              (bus.rom_addr[31:DEPTH_LOG2+2] == '0);
    assign bus.rom_inst     = fetch_hit ? mem[fetch_idx] : 32'h0000_0000;
    assign unused_addr_bits = ^bus.rom_addr[1:0];

    // ---------------- loader handshake ----------------
    assign ready_int      = (state_reg == LOAD) && !bus.load_start;
    assign accept         = ready_int && bus.load_valid;
    assign bus.load_ready = ready_int;
    assign bus.load_busy  = (state_reg == LOAD);
    assign bus.load_done  = done_reg;
    assign bus.load_err   = err_reg;
    assign bus.load_words = words_reg;

    // Assembled word including the byte arriving this cycle. Lanes past the
    // current byte come from asm_reg, which is kept zero there, so a word
    // closed early by load_last is zero-padded automatically.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_fill[31-8*gi -: 8] = (cnt_reg == 2'(gi)) ? bus.load_byte
                                                                : asm_reg[31-8*gi -: 8];
        end
    endgenerate

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        words_next = words_reg;
        cnt_next   = cnt_reg;
        asm_next   = asm_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        wr_en      = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.load_start) begin
                    state_next = LOAD;
                    words_next = '0;
                    cnt_next   = '0;
                    asm_next   = '0;
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                end
            end
            LOAD: begin
                if (bus.load_start) begin
                    // Restart: drop the partial word, keep written words.
                    words_next = '0;
                    cnt_next   = '0;
                    asm_next   = '0;
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                end else if (accept) begin
                    if (cnt_reg == 2'd3 || bus.load_last) begin
                        wr_en      = !rst;
                        words_next = words_reg + ONE_WORD;
                        cnt_next   = '0;
                        asm_next   = '0;
                        if (bus.load_last) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end else if (words_reg == LAST_WORD) begin
                            // Array full with more image to come: stop here
                            // instead of wrapping over word 0.
                            state_next = DONE;
                            done_next  = 1'b1;
                            err_next   = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 2'd1;
                        asm_next = word_fill;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_reg <= '0;
            cnt_reg   <= '0;
            asm_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            words_reg <= words_next;
            cnt_reg   <= cnt_next;
            asm_reg   <= asm_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Array has no reset: its contents survive rst so the core can run from it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[words_reg[DEPTH_LOG2-1:0]] <= word_fill;
        end
    end
endmodule

// File: tb/tb_inst_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_loader
//
// Small array (4 words) so overflow is reachable. A queue-based model of the
// loader runs on the rising edge; a compare process checks every DUT output
// against it on the falling edge. Directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_inst_rom_loader;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_rom_loader_if #(.DEPTH_LOG2(DL)) bus ();
    inst_rom_loader #(.DEPTH_LOG2(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_loading = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_err     = 1'b0;
    int          m_words   = 0;
    logic [7:0]  m_part[$];
    logic [31:0] m_mem[DEPTH];
    bit          m_known[DEPTH];
    logic [31:0] m_w;

    always @(posedge clk) begin
        if (rst) begin
            m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0; m_words = 0;
            m_part.delete();
        end else if (bus.load_start) begin
            m_loading = 1'b1; m_done = 1'b0; m_err = 1'b0; m_words = 0;
            m_part.delete();
        end else if (m_loading && bus.load_valid) begin
            m_part.push_back(bus.load_byte);
            if (m_part.size() == 4 || bus.load_last) begin
                m_w = 32'h0;
                for (int i = 0; i < m_part.size(); i++)
                    m_w = m_w | (32'(m_part[i]) << (24 - 8 * i));
                m_mem[m_words]   = m_w;
                m_known[m_words] = 1'b1;
                m_words++;
                m_part.delete();
                if (bus.load_last) begin
                    m_loading = 1'b0; m_done = 1'b1;
                end else if (m_words == DEPTH) begin
                    m_loading = 1'b0; m_done = 1'b1; m_err = 1'b1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic [DL-1:0] c_idx;
    bit            c_in_range;
    always @(negedge clk) begin
        if (check_en) begin
            chk("load_ready", 32'(bus.load_ready), 32'(m_loading && !bus.load_start));
            chk("load_busy",  32'(bus.load_busy),  32'(m_loading));
            chk("load_done",  32'(bus.load_done),  32'(m_done));
            chk("load_err",   32'(bus.load_err),   32'(m_err));
            chk("load_words", 32'(bus.load_words), 32'(m_words));
            c_in_range = (bus.rom_addr >> (DL + 2)) == 0;
            c_idx      = bus.rom_addr[DL+1:2];
            if (!bus.rom_en || m_loading || !c_in_range)
                chk("rom_inst_nop", bus.rom_inst, 32'h0);
            else if (m_known[c_idx])
                chk("rom_inst", bus.rom_inst, m_mem[c_idx]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bus.rom_en = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 9))
            0:       bus.rom_addr = $urandom;
            1:       bus.rom_addr = $urandom_range(DEPTH * 4, DEPTH * 8 - 1);
            default: bus.rom_addr = $urandom_range(0, DEPTH * 4 - 1);
        endcase
    endtask

    task automatic fetch_check(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus.rom_en   = 1'b1;
        bus.rom_addr = a;
        #1;
        chk(name, bus.rom_inst, exp);
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        bus.load_valid = ($urandom_range(0, 1) == 1);   // must be ignored
        bus.load_byte  = 8'($urandom);
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'($urandom_range(0, 1));
        bus.load_byte  = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic load_image(input bq_t img, input bit use_last, input int gap);
        start_load();
        for (int i = 0; i < img.size(); i++)
            send_byte(img[i], use_last && (i == img.size() - 1), gap);
        tick();
        $display("load: %0d bytes last=%0d gap=%0d -> words=%0d done=%0d err=%0d",
                 img.size(), use_last, gap, bus.load_words, bus.load_done, bus.load_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t img1;
        bq_t img2;
        bq_t ovf;
        bq_t rnd;
        int  len;
        bit  use_last;

        bus.rom_en = 1'b0; bus.rom_addr = 32'h0;
        bus.load_start = 1'b0; bus.load_valid = 1'b0;
        bus.load_byte = 8'h0; bus.load_last = 1'b0;

        // Reset, two cycles
        rst = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ready", 32'(bus.load_ready), 32'h0);
        chk("rst_busy",  32'(bus.load_busy),  32'h0);
        chk("rst_done",  32'(bus.load_done),  32'h0);
        chk("rst_err",   32'(bus.load_err),   32'h0);
        chk("rst_words", 32'(bus.load_words), 32'h0);
        fetch_check(32'h0000_0100, 32'h0, "rst_fetch_oob");
        bus.rom_en = 1'b0; bus.rom_addr = 32'h0; #1;
        chk("rst_fetch_disabled", bus.rom_inst, 32'h0);
        tick();

        // Two-word image, fetch NOP while loading
        img1 = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        start_load();
        send_byte(img1[0], 1'b0, 0);
        fetch_check(32'h0, 32'h0, "fetch_during_load");
        for (int i = 1; i < 8; i++) send_byte(img1[i], i == 7, 0);
        tick();
        $display("load: 8 bytes directed -> words=%0d", bus.load_words);
        chk("img1_words", 32'(bus.load_words), 32'd2);
        chk("img1_done",  32'(bus.load_done),  32'd1);
        chk("img1_busy",  32'(bus.load_busy),  32'd0);
        chk("model_img1_word0", m_mem[0], 32'h3401_0005);
        fetch_check(32'h0, 32'h3401_0005, "img1_fetch0");
        fetch_check(32'h4, 32'h0, "img1_fetch4");
        fetch_check(32'h6, 32'h0, "img1_fetch6");
        tick();

        // Short image: zero-padded partial word
        img2 = '{8'hAA, 8'hBB};
        load_image(img2, 1'b1, 0);
        chk("img2_words", 32'(bus.load_words), 32'd1);
        chk("model_img2_word0", m_mem[0], 32'hAABB_0000);
        fetch_check(32'h0, 32'hAABB_0000, "img2_fetch0");
        tick();

        // Gapped stream gives the same image
        load_image(img1, 1'b1, 3);
        chk("gap_words", 32'(bus.load_words), 32'd2);
        fetch_check(32'h0, 32'h3401_0005, "gap_fetch0");
        tick();

        // Overflow: 20 bytes without load_last into a 4-word array
        for (int i = 0; i < 20; i++) ovf.push_back(8'(8'h10 + i));
        load_image(ovf, 1'b0, 0);
        chk("ovf_err",   32'(bus.load_err),   32'd1);
        chk("ovf_done",  32'(bus.load_done),  32'd1);
        chk("ovf_ready", 32'(bus.load_ready), 32'd0);
        chk("ovf_words", 32'(bus.load_words), 32'd4);
        chk("model_ovf_err", 32'(m_err), 32'd1);
        fetch_check(32'h10, 32'h0, "ovf_fetch_oob");
        fetch_check(32'hC, 32'h1C1D_1E1F, "ovf_fetch_last");
        tick();

        // Restart mid-load discards the partial word
        start_load();
        send_byte(8'h60, 1'b0, 0);
        send_byte(8'h61, 1'b0, 0);
        start_load();
        for (int i = 0; i < 4; i++) send_byte(8'(8'h70 + i), i == 3, 0);
        tick();
        $display("load: restart -> words=%0d", bus.load_words);
        chk("restart_words", 32'(bus.load_words), 32'd1);
        fetch_check(32'h0, 32'h7071_7273, "restart_fetch0");
        fetch_check(32'h4, 32'h1415_1617, "restart_fetch1");
        tick();

        // Reset after 6 bytes
        start_load();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h50 + i), 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("load: reset after 6 bytes -> busy=%0d words=%0d", bus.load_busy, bus.load_words);
        chk("rstmid_busy",  32'(bus.load_busy),  32'd0);
        chk("rstmid_words", 32'(bus.load_words), 32'd0);
        fetch_check(32'h0, 32'h5051_5253, "rstmid_fetch0");
        fetch_check(32'h4, 32'h1415_1617, "rstmid_fetch1");
        tick();

        // Randomized loads with restarts and occasional reset
        for (int n = 0; n < 40; n++) begin
            len      = $urandom_range(1, 18);
            use_last = ($urandom_range(0, 3) != 0);
            start_load();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 29) == 0) start_load();
                if ($urandom_range(0, 49) == 0) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                end
                send_byte(8'($urandom), use_last && (i == len - 1), $urandom_range(0, 2));
            end
            repeat ($urandom_range(1, 4)) tick();
            $display("load: random %0d len=%0d last=%0d -> words=%0d done=%0d err=%0d",
                     n, len, use_last, bus.load_words, bus.load_done, bus.load_err);
        end

        repeat (3) tick();
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
